// File: rtl/peak_frame_sequencer.sv
// peak_frame_sequencer: collects per-channel frame-complete pulses, then streams
// one full frame of peak values/indices into the free bank of a 2-bank DPRAM,
// with ping-pong bank ownership handshake and dropped-frame tracking.
module peak_frame_sequencer #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned NUM_PEAKS   = 16,
  parameter int unsigned VALUE_WIDTH = 24,
  parameter int unsigned INDEX_WIDTH = 11,
  parameter int unsigned ADDR_WIDTH  = 7
) (
  input  logic                                      clk,
  input  logic                                      aresetn,
  input  logic                                      enable,
  input  logic [CHANNELS-1:0]                       ch_done,
  input  logic [CHANNELS*NUM_PEAKS*VALUE_WIDTH-1:0] peaks,
  input  logic [CHANNELS*NUM_PEAKS*INDEX_WIDTH-1:0] indices,
  input  logic                                      buf_ack,
  input  logic                                      ack_bank,
  input  logic                                      overrun_clr,
  output logic                                      wr_en,
  output logic [ADDR_WIDTH:0]                       wr_addr,
  output logic [VALUE_WIDTH-1:0]                    wr_peak,
  output logic [INDEX_WIDTH-1:0]                    wr_index,
  output logic                                      peaks_ready,
  output logic                                      ready_bank,
  output logic [1:0]                                bank_full,
  output logic                                      overrun,
  output logic [15:0]                               frame_count
);

  localparam int unsigned N = CHANNELS * NUM_PEAKS;
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [CHANNELS-1:0]     done_lat;
  logic                    wr_bank;

  logic                    frame_ready_c;
  logic                    drop_c;
  logic                    done_c;
  logic [1:0]              ack_mask_c;
  logic [1:0]              set_mask_c;

  logic [VALUE_WIDTH-1:0]  peak_arr  [N];
  logic [INDEX_WIDTH-1:0]  index_arr [N];

  // Unpack the flat result buses so entry k can be selected by the counter
  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign peak_arr[k]  = peaks[k*VALUE_WIDTH +: VALUE_WIDTH];
    assign index_arr[k] = indices[k*INDEX_WIDTH +: INDEX_WIDTH];
  end

  // A complete frame is being taken out of WAIT (either written or dropped)
  assign frame_ready_c = (state == S_WAIT) && enable && (&done_lat);
  assign drop_c        = frame_ready_c && bank_full[wr_bank];
  assign done_c        = (state == S_DONE);
  assign ack_mask_c    = {ack_bank, ~ack_bank} & {2{buf_ack}};
  assign set_mask_c    = {wr_bank, ~wr_bank} & {2{done_c}};

  // Frame-complete latches: cleared when a frame leaves WAIT, new pulses win
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      done_lat <= '0;
    end else begin
      done_lat <= (frame_ready_c ? '0 : done_lat) | ch_done;
    end
  end

  // Sequencer FSM and write counter
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if ((&done_lat) && !bank_full[wr_bank]) begin
            state <= S_WRITE;
            cnt   <= '0;
          end
        end
        S_WRITE: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_CNT) state <= S_DONE;
        end
        S_DONE: begin
          state <= enable ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered write port: one entry per WRITE cycle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_peak  <= '0;
      wr_index <= '0;
    end else begin
      wr_en <= (state == S_WRITE);
      if (state == S_WRITE) begin
        wr_addr  <= {wr_bank, cnt};
        wr_peak  <= peak_arr[cnt];
        wr_index <= index_arr[cnt];
      end
    end
  end

  // Bank ownership, completion signalling and frame statistics
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_bank     <= 1'b0;
      ready_bank  <= 1'b0;
      peaks_ready <= 1'b0;
      bank_full   <= 2'b00;
      frame_count <= '0;
    end else begin
      peaks_ready <= done_c;
      bank_full   <= (bank_full & ~ack_mask_c) | set_mask_c;
      if (done_c) begin
        ready_bank  <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Sticky dropped-frame flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overrun <= 1'b0;
    end else begin
      overrun <= (overrun & ~overrun_clr) | drop_c;
    end
  end

endmodule

// File: tb/tb_peak_frame_sequencer.sv
// Self-checking bench for peak_frame_sequencer: table of frame vectors plus
// directed sequences for the multi-cycle corner cases.
module tb_peak_frame_sequencer;

  localparam int CH = 8;
  localparam int NP = 16;
  localparam int VW = 24;
  localparam int IW = 11;
  localparam int AW = 7;
  localparam int N  = CH * NP;

  logic                clk;
  logic                aresetn;
  logic                enable;
  logic [CH-1:0]       ch_done;
  logic [N*VW-1:0]     peaks;
  logic [N*IW-1:0]     indices;
  logic                buf_ack;
  logic                ack_bank;
  logic                overrun_clr;
  logic                wr_en;
  logic [AW:0]         wr_addr;
  logic [VW-1:0]       wr_peak;
  logic [IW-1:0]       wr_index;
  logic                peaks_ready;
  logic                ready_bank;
  logic [1:0]          bank_full;
  logic                overrun;
  logic [15:0]         frame_count;

  peak_frame_sequencer #(
    .CHANNELS(CH), .NUM_PEAKS(NP), .VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .ch_done(ch_done),
    .peaks(peaks), .indices(indices), .buf_ack(buf_ack), .ack_bank(ack_bank),
    .overrun_clr(overrun_clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_peak(wr_peak),
    .wr_index(wr_index), .peaks_ready(peaks_ready), .ready_bank(ready_bank),
    .bank_full(bank_full), .overrun(overrun), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   seed = 0;
  logic exp_bank = 1'b0;
  int   mon_idx = 0;
  int   wr_total = 0;
  int   pr_count = 0;
  logic prev_wr = 1'b0;

  typedef struct {
    logic       ack;
    logic       ack_bank;
    logic       exp_write;
    logic       exp_bank;
    logic [1:0] exp_full;
    logic       exp_ovr;
    int         exp_fc;
    logic       exp_ready;
  } frame_vec_t;

  frame_vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] exp_peak(input int k);
    return VW'(seed * 4099 + k * 77 + 1);
  endfunction

  function automatic logic [IW-1:0] exp_index(input int k);
    return IW'((k * 5) ^ (seed * 13));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame_data();
    seed++;
    for (int k = 0; k < N; k++) begin
      peaks[k*VW +: VW]   = exp_peak(k);
      indices[k*IW +: IW] = exp_index(k);
    end
  endtask

  task automatic ack(input logic b);
    buf_ack  = 1'b1;
    ack_bank = b;
    tick();
    buf_ack  = 1'b0;
  endtask

  task automatic pulse_done(input logic [CH-1:0] m);
    ch_done = m;
    tick();
    ch_done = '0;
  endtask

  task automatic wait_addr(input int k);
    bit found = 0;
    for (int i = 0; i < 400; i++) begin
      if (wr_en && (int'(wr_addr[AW-1:0]) == k)) begin
        found = 1;
        break;
      end
      tick();
    end
    chk($sformatf("wait_addr_%0d", k), 64'(found), 64'd1);
  endtask

  task automatic wait_ready();
    bit found = 0;
    for (int i = 0; i < 400; i++) begin
      if (peaks_ready) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("wait_peaks_ready", 64'(found), 64'd1);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_wr_en"},       64'(wr_en),       64'd0);
    chk({tag, "_wr_addr"},     64'(wr_addr),     64'd0);
    chk({tag, "_wr_peak"},     64'(wr_peak),     64'd0);
    chk({tag, "_wr_index"},    64'(wr_index),    64'd0);
    chk({tag, "_peaks_ready"}, 64'(peaks_ready), 64'd0);
    chk({tag, "_ready_bank"},  64'(ready_bank),  64'd0);
    chk({tag, "_bank_full"},   64'(bank_full),   64'd0);
    chk({tag, "_overrun"},     64'(overrun),     64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
  endtask

  // Write-port monitor: address sequence, data and contiguity of every write
  always @(negedge clk) begin
    if (wr_en) begin
      if (mon_idx >= N) begin
        chk("extra_write", 64'(mon_idx), 64'(N - 1));
      end else begin
        chk("wr_addr", 64'(wr_addr), 64'({exp_bank, AW'(mon_idx)}));
        chk("wr_peak", 64'(wr_peak), 64'(exp_peak(mon_idx)));
        chk("wr_index", 64'(wr_index), 64'(exp_index(mon_idx)));
        if (mon_idx != 0 && !prev_wr) chk("wr_contiguous", 64'(prev_wr), 64'd1);
      end
      mon_idx++;
      wr_total++;
    end
    if (peaks_ready) pr_count++;
    prev_wr = wr_en;
  end

  initial begin
    int w0;
    int p0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 3, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 4, 1'b1};

    aresetn = 1'b0; enable = 1'b0; ch_done = '0; peaks = '0; indices = '0;
    buf_ack = 1'b0; ack_bank = 1'b0; overrun_clr = 1'b0;
    repeat (3) tick();
    chk_all_reset("in_reset");
    @(negedge clk);
    aresetn = 1'b1;
    tick();
    chk_all_reset("after_reset");

    enable = 1'b1;
    repeat (2) tick();

    // Frame table: staggered channel completions, fixed observation window
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].ack) ack(vecs[v].ack_bank);
      new_frame_data();
      exp_bank = vecs[v].exp_bank;
      mon_idx  = 0;
      w0 = wr_total;
      p0 = pr_count;
      for (int c = 0; c < CH; c++) begin
        pulse_done(CH'(1) << c);
        repeat (6) tick();
      end
      repeat (150) tick();
      chk($sformatf("v%0d_writes", v), 64'(wr_total - w0), vecs[v].exp_write ? 64'(N) : 64'd0);
      chk($sformatf("v%0d_ready_pulses", v), 64'(pr_count - p0), 64'(vecs[v].exp_write));
      chk($sformatf("v%0d_bank_full", v), 64'(bank_full), 64'(vecs[v].exp_full));
      chk($sformatf("v%0d_overrun", v), 64'(overrun), 64'(vecs[v].exp_ovr));
      chk($sformatf("v%0d_frame_count", v), 64'(frame_count), 64'(vecs[v].exp_fc));
      chk($sformatf("v%0d_ready_bank", v), 64'(ready_bank), 64'(vecs[v].exp_ready));
    end

    // Overrun clear, then clear coinciding with a dropped frame
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);
    w0 = wr_total;
    pulse_done('1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr_set_beats_clr", 64'(overrun), 64'd1);
    repeat (10) tick();
    chk("drop_no_write", 64'(wr_total - w0), 64'd0);
    chk("drop_fc", 64'(frame_count), 64'd4);

    // Release both banks, and ack an already-empty bank
    ack(1'b0); ack(1'b1);
    chk("acked_both", 64'(bank_full), 64'd0);
    ack(1'b0);
    chk("ack_empty", 64'(bank_full), 64'd0);

    // Ack of bank 0 in the DONE cycle for bank 0: set wins
    new_frame_data();
    exp_bank = 1'b0; mon_idx = 0; p0 = pr_count;
    pulse_done('1);
    wait_addr(N - 1);
    buf_ack = 1'b1; ack_bank = 1'b0; tick(); buf_ack = 1'b0;
    chk("done_ack_ready", 64'(peaks_ready), 64'd1);
    chk("done_ack_full", 64'(bank_full), 64'b01);
    chk("done_ack_fc", 64'(frame_count), 64'd5);
    tick();
    chk("done_ack_pulse_once", 64'(pr_count - p0), 64'd1);

    // Early done: ch5 in the exit-WAIT cycle and ch3 during WRITE are kept
    new_frame_data();
    exp_bank = 1'b1; mon_idx = 0;
    ch_done = '1; tick();
    ch_done = 8'h20; tick();
    ch_done = '0;
    repeat (10) tick();
    pulse_done(8'h08);
    wait_ready();
    chk("early_fc", 64'(frame_count), 64'd6);
    chk("early_ready_bank", 64'(ready_bank), 64'd1);
    tick();
    ack(1'b0);
    new_frame_data();
    exp_bank = 1'b0; mon_idx = 0; w0 = wr_total;
    pulse_done(8'h57);
    repeat (20) tick();
    chk("early_partial_nowrite", 64'(wr_total - w0), 64'd0);
    pulse_done(8'h80);
    wait_ready();
    tick();
    chk("early_writes", 64'(wr_total - w0), 64'(N));
    chk("early_fc2", 64'(frame_count), 64'd7);
    chk("early_full", 64'(bank_full), 64'b11);

    // Enable dropped mid-WRITE: frame completes, then IDLE latches only
    ack(1'b1);
    new_frame_data();
    exp_bank = 1'b1; mon_idx = 0; w0 = wr_total;
    pulse_done('1);
    wait_addr(40);
    enable = 1'b0;
    wait_ready();
    tick();
    chk("endrop_writes", 64'(wr_total - w0), 64'(N));
    chk("endrop_fc", 64'(frame_count), 64'd8);
    pulse_done('1);
    repeat (20) tick();
    chk("idle_nowrite", 64'(wr_total - w0), 64'(N));
    ack(1'b0);
    new_frame_data();
    exp_bank = 1'b0; mon_idx = 0; w0 = wr_total;
    enable = 1'b1;
    wait_ready();
    tick();
    chk("idle_latched_writes", 64'(wr_total - w0), 64'(N));
    chk("idle_latched_fc", 64'(frame_count), 64'd9);

    // Reset mid-WRITE at cnt=60
    ack(1'b1);
    new_frame_data();
    exp_bank = 1'b1; mon_idx = 0;
    pulse_done('1);
    wait_addr(60);
    #2 aresetn = 1'b0;
    #1;
    chk_all_reset("midwrite_reset");
    @(negedge clk);
    aresetn = 1'b1;
    w0 = wr_total; p0 = pr_count;
    repeat (150) tick();
    chk("post_reset_nowrite", 64'(wr_total - w0), 64'd0);
    chk("post_reset_no_ready", 64'(pr_count - p0), 64'd0);
    chk("post_reset_full", 64'(bank_full), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
